// File: rtl/wb_dsp_equation_fetch_if.sv
// Wishbone classic master/slave bundle used by the equation-record fetcher.
// Handshake: the master holds cyc/stb with a stable address until the slave answers with ack (data valid) or err.
interface wb_dsp_equation_fetch_if;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_ack_i;
    logic        m_err_i;

    modport master (
        output m_adr_o,
        output m_sel_o,
        output m_we_o,
        output m_cyc_o,
        output m_stb_o,
        input  m_dat_i,
        input  m_ack_i,
        input  m_err_i
    );

    modport slave (
        input  m_adr_o,
        input  m_sel_o,
        input  m_we_o,
        input  m_cyc_o,
        input  m_stb_o,
        output m_dat_i,
        output m_ack_i,
        output m_err_i
    );
endinterface

// File: rtl/wb_dsp_equation_fetch.sv
// Fetches a four-word equation record over a Wishbone master port and presents it on eq_*.
// Optional fetch watchdog: define WB_DSP_FETCH_TIMEOUT_EN to enable the 255-cycle FETCH timeout.
module wb_dsp_equation_fetch (
    input  logic                           wb_clk,
    input  logic                           wb_rst_n,
    input  logic [31:0]                    control_reg,
    input  logic [31:0]                    equation_address_reg,
    output logic [31:0]                    status_reg,
    wb_dsp_equation_fetch_if.master        wb,
    output logic [31:0]                    eq_op,
    output logic [31:0]                    eq_src0,
    output logic [31:0]                    eq_src1,
    output logic [31:0]                    eq_dst,
    output logic                           eq_valid,
    output logic                           interrupt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_adr;
    logic        r_cyc;
    logic        r_stb;
    logic [31:0] r_eq_op;
    logic [31:0] r_eq_src0;
    logic [31:0] r_eq_src1;
    logic [31:0] r_eq_dst;
    logic        r_eq_valid;
    logic        r_done;
    logic        r_err;
    logic        r_abort;
    logic        r_irq;
    logic        r_start_low;

    logic        w_start_edge;
    logic        w_accept_start;
    logic        w_abort;
    logic        w_ie;
    logic        w_busy;
    logic        w_tmo_hit;
    logic        w_tmo_flag;
    logic        w_unused;

    // r_start_low resets to 0, so a START already high at reset release is not an edge.
    assign w_start_edge   = control_reg[0] & r_start_low;
    assign w_accept_start = (r_state == ST_IDLE) && w_start_edge;
    assign w_abort        = control_reg[1];
    assign w_ie           = control_reg[2];
    assign w_busy         = (r_state != ST_IDLE);
    assign w_unused       = ^{control_reg[31:3], equation_address_reg[1:0]};

`ifdef WB_DSP_FETCH_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_tmo;

    // Counter is held at 0 outside FETCH, so every entry into FETCH starts a fresh count.
    assign w_tmo_hit  = (r_state == ST_FETCH) && !wb.m_ack_i && !wb.m_err_i && (r_tmo_cnt == 8'd254);
    assign w_tmo_flag = r_tmo;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_tmo_cnt <= 8'd0;
            r_tmo     <= 1'b0;
        end else begin
            if (w_accept_start) begin
                r_tmo <= 1'b0;
            end else if (w_tmo_hit && !w_abort) begin
                r_tmo <= 1'b1;
            end

            if (r_state != ST_FETCH) begin
                r_tmo_cnt <= 8'd0;
            end else if (!wb.m_ack_i && !wb.m_err_i) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end
`else
    assign w_tmo_hit  = 1'b0;
    assign w_tmo_flag = 1'b0;
`endif

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_adr       <= 32'd0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_eq_op     <= 32'd0;
            r_eq_src0   <= 32'd0;
            r_eq_src1   <= 32'd0;
            r_eq_dst    <= 32'd0;
            r_eq_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
            r_irq       <= 1'b0;
            r_start_low <= 1'b0;
        end else begin
            r_start_low <= ~control_reg[0];
            r_eq_valid  <= 1'b0;

            // Abort deliberately absent: only completion, bus error or timeout interrupt.
            if (w_accept_start) begin
                r_irq <= 1'b0;
            end else if (w_ie && (r_done || r_err || w_tmo_flag)) begin
                r_irq <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_adr   <= {equation_address_reg[31:2], 2'b00};
                        r_idx   <= 2'd0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_abort <= 1'b0;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    // Abort beats err beats ack; a word arriving with abort or err is dropped.
                    if (w_abort) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_abort <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (wb.m_err_i) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (wb.m_ack_i) begin
                        case (r_idx)
                            2'd0:    r_eq_op   <= wb.m_dat_i;
                            2'd1:    r_eq_src0 <= wb.m_dat_i;
                            2'd2:    r_eq_src1 <= wb.m_dat_i;
                            default: r_eq_dst  <= wb.m_dat_i;
                        endcase
                        if (r_idx == 2'd3) begin
                            r_cyc      <= 1'b0;
                            r_stb      <= 1'b0;
                            r_eq_valid <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_stb   <= 1'b0;
                            r_idx   <= r_idx + 2'd1;
                            r_adr   <= r_adr + 32'd4;
                            r_state <= ST_GAP;
                        end
                    end else if (w_tmo_hit) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_GAP: begin
                    if (w_abort) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_abort <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_stb   <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end

                ST_DONE: begin
                    // idx returns to 0 so a completed record reads back as plain done.
                    r_idx   <= 2'd0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb.m_adr_o = r_adr;
    assign wb.m_sel_o = 4'hF;
    assign wb.m_we_o  = 1'b0;
    assign wb.m_cyc_o = r_cyc;
    assign wb.m_stb_o = r_stb;

    assign eq_op     = r_eq_op;
    assign eq_src0   = r_eq_src0;
    assign eq_src1   = r_eq_src1;
    assign eq_dst    = r_eq_dst;
    assign eq_valid  = r_eq_valid;
    assign interrupt = r_irq;

    assign status_reg = {22'd0, r_state, 1'b0, r_idx, r_abort, w_tmo_flag, r_err, r_done, w_busy};

endmodule

// File: tb/tb_wb_dsp_equation_fetch.sv
// Randomized bench for wb_dsp_equation_fetch: a Wishbone slave with random wait states plus a record-level model.
// Build with or without WB_DSP_FETCH_TIMEOUT_EN; the timeout section follows the same macro.
module tb_wb_dsp_equation_fetch;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [31:0] control_reg = 32'd0;
    logic [31:0] equation_address_reg = 32'd0;
    logic [31:0] status_reg;
    logic [31:0] eq_op;
    logic [31:0] eq_src0;
    logic [31:0] eq_src1;
    logic [31:0] eq_dst;
    logic        eq_valid;
    logic        interrupt;

    wb_dsp_equation_fetch_if wb ();

    wb_dsp_equation_fetch dut (
        .wb_clk               (wb_clk),
        .wb_rst_n             (wb_rst_n),
        .control_reg          (control_reg),
        .equation_address_reg (equation_address_reg),
        .status_reg           (status_reg),
        .wb                   (wb),
        .eq_op                (eq_op),
        .eq_src0              (eq_src0),
        .eq_src1              (eq_src1),
        .eq_dst               (eq_dst),
        .eq_valid             (eq_valid),
        .interrupt            (interrupt)
    );

    always #5 wb_clk = ~wb_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_eq[4];
    logic [31:0] words[4];
    logic [31:0] fixed_words[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic check_record(input string tag);
        check_eq({tag, "_op"},   eq_op,   exp_eq[0]);
        check_eq({tag, "_src0"}, eq_src0, exp_eq[1]);
        check_eq({tag, "_src1"}, eq_src1, exp_eq[2]);
        check_eq({tag, "_dst"},  eq_dst,  exp_eq[3]);
    endtask

    // mode 0: complete record; 1: err on word k; 2: abort in the gap after word k; 3: abort together with ack of word k
    task automatic run_fetch(input logic [31:0] addr_reg, input int mode, input int k,
                             input bit ie, input bit fixed);
        logic [31:0] base;
        logic [31:0] idx_w;
        logic [31:0] exp_status;
        bit          exp_irq;
        int          n_req;
        int          acked = 0;
        int          wait_c;
        int          cycles = 0;
        int          vcount = 0;
        int          post = -1;
        bit          gap_exp = 0;
        bit          abort_next = 0;
        bit          frozen = 0;

        base = addr_reg & 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) words[i] = fixed ? fixed_words[i] : $urandom();
        n_req = (mode == 0) ? 4 : k + 1;
        exp_q.delete();
        for (int i = 0; i < n_req; i++) exp_q.push_back(base + 32'(4 * i));
        case (mode)
            0:       exp_status = 32'h002;
            1:       exp_status = 32'h004 | 32'(k << 5);
            2:       exp_status = 32'h010 | 32'((k + 1) << 5);
            default: exp_status = 32'h010 | 32'(k << 5);
        endcase
        exp_irq = ie && (mode < 2);

        wb.m_ack_i = 1'b0;
        wb.m_err_i = 1'b0;
        wb.m_dat_i = 32'd0;
        control_reg = {29'd0, ie, 2'b00};
        equation_address_reg = addr_reg;
        step();
        control_reg[0] = 1'b1;
        step();
        wait_c = $urandom_range(0, 2);

        while (post != 0 && cycles < 400) begin
            cycles++;
            if (eq_valid) vcount++;
            if (gap_exp) begin
                check_eq("gap_cyc", wb.m_cyc_o, 1);
                check_eq("gap_stb", wb.m_stb_o, 0);
            end
            gap_exp = 0;
            if (post == 5) begin
                check_eq("cyc_drop", wb.m_cyc_o, 0);
                check_eq("stb_drop", wb.m_stb_o, 0);
            end
            if (post > 0) post--;

            wb.m_ack_i = 1'b0;
            wb.m_err_i = 1'b0;
            control_reg[1] = 1'b0;
            if (post < 0) begin
                // START edges mid-record must be ignored; stop toggling once the record ends.
                if (!frozen) control_reg[0] = ($urandom_range(0, 3) != 0);
                if (abort_next) begin
                    control_reg[1] = 1'b1;
                    abort_next = 0;
                    frozen = 1;
                    post = 5;
                end else if (wb.m_cyc_o && wb.m_stb_o) begin
                    if (wait_c > 0) begin
                        wait_c--;
                    end else begin
                        check_eq("req_pending", 32'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) check_eq("adr", wb.m_adr_o, exp_q.pop_front());
                        idx_w = (wb.m_adr_o - base) >> 2;
                        wb.m_dat_i = (idx_w < 4) ? words[idx_w[1:0]] : 32'hBAD0_BAD0;
                        if (mode == 1 && acked == k) begin
                            wb.m_err_i = 1'b1;
                            wb.m_ack_i = 1'($urandom_range(0, 1));
                            frozen = 1;
                            post = 5;
                        end else if (mode == 3 && acked == k) begin
                            wb.m_ack_i = 1'b1;
                            control_reg[1] = 1'b1;
                            frozen = 1;
                            post = 5;
                        end else begin
                            wb.m_ack_i = 1'b1;
                            exp_eq[acked] = words[acked];
                            acked++;
                            if (acked == 4) begin
                                frozen = 1;
                                post = 5;
                            end else begin
                                gap_exp = 1;
                                if (mode == 2 && acked == k + 1) abort_next = 1;
                            end
                        end
                        wait_c = $urandom_range(0, 2);
                    end
                end
            end
            step();
        end

        wb.m_ack_i = 1'b0;
        wb.m_err_i = 1'b0;
        control_reg[1] = 1'b0;
        check_eq("run_budget", 32'(post == 0), 1);
        check_eq("req_left", exp_q.size(), 0);
        check_eq("eq_valid_cnt", vcount, (mode == 0) ? 1 : 0);
        check_eq("status", status_reg, exp_status);
        check_eq("irq", interrupt, exp_irq);
        check_eq("cyc_idle", wb.m_cyc_o, 0);
        check_eq("sel", wb.m_sel_o, 4'hF);
        check_eq("we", wb.m_we_o, 0);
        check_record("rec");
    endtask

    initial begin
        int cnt;
        int mode;
        int k;
        bit restarted;

        fixed_words[0] = 32'hA1;
        fixed_words[1] = 32'hB2;
        fixed_words[2] = 32'hC3;
        fixed_words[3] = 32'hD4;
        for (int i = 0; i < 4; i++) exp_eq[i] = 32'd0;
        wb.m_ack_i = 1'b0;
        wb.m_err_i = 1'b0;
        wb.m_dat_i = 32'd0;

        // Clock/reset
        step();
        step();
        check_eq("rst_cyc", wb.m_cyc_o, 0);
        check_eq("rst_stb", wb.m_stb_o, 0);
        check_eq("rst_adr", wb.m_adr_o, 0);
        check_eq("rst_status", status_reg, 0);
        check_eq("rst_irq", interrupt, 0);
        check_eq("rst_valid", eq_valid, 0);
        check_record("rst");
        wb_rst_n = 1'b1;
        step();

        // Known record at 0x100, then ABORT while idle must change nothing
        run_fetch(32'h100, 0, 0, 1, 1);
        control_reg[1] = 1'b1;
        step();
        step();
        step();
        check_eq("idle_abort_status", status_reg, 32'h002);
        check_eq("idle_abort_cyc", wb.m_cyc_o, 0);
        check_eq("idle_abort_irq", interrupt, 1);
        control_reg[1] = 1'b0;

        run_fetch(32'h103, 0, 0, 0, 0);
        run_fetch(32'h300, 1, 2, 1, 0);
        run_fetch(32'h400, 2, 1, 1, 0);
        run_fetch(32'h400, 0, 0, 1, 0);
        run_fetch(32'hFFFF_FFF8, 0, 0, 1, 0);
        run_fetch(32'h500, 3, 1, 1, 0);

        for (int r = 0; r < 8; r++) begin
            mode = $urandom_range(0, 3);
            k = (mode == 2) ? $urandom_range(0, 2) : $urandom_range(0, 3);
            run_fetch($urandom(), mode, k, 1'($urandom_range(0, 1)), 0);
        end

        // Slave that never answers
        control_reg = {29'd0, 1'b1, 2'b00};
        equation_address_reg = 32'h200;
        step();
        control_reg[0] = 1'b1;
        step();
        check_eq("tmo_adr", wb.m_adr_o, 32'h200);
`ifdef WB_DSP_FETCH_TIMEOUT_EN
        cnt = 0;
        while (wb.m_cyc_o && cnt < 400) begin
            cnt++;
            step();
        end
        check_eq("tmo_cycles", cnt, 255);
        step();
        step();
        check_eq("tmo_status", status_reg, 32'h008);
        check_eq("tmo_irq", interrupt, 1);
`else
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (wb.m_cyc_o) cnt++;
            step();
        end
        check_eq("no_tmo_cycles", cnt, 1000);
        check_eq("no_tmo_status", status_reg, 32'h101);
        check_eq("no_tmo_irq", interrupt, 0);
`endif

        // Reset in the middle of FETCH with START held high
        control_reg[0] = 1'b0;
        step();
        control_reg[0] = 1'b1;
        step();
        step();
        check_eq("pre_rst_cyc", wb.m_cyc_o, 1);
        wb_rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) exp_eq[i] = 32'd0;
        check_eq("mid_rst_cyc", wb.m_cyc_o, 0);
        check_eq("mid_rst_stb", wb.m_stb_o, 0);
        check_eq("mid_rst_adr", wb.m_adr_o, 0);
        check_eq("mid_rst_status", status_reg, 0);
        check_eq("mid_rst_irq", interrupt, 0);
        check_eq("mid_rst_valid", eq_valid, 0);
        check_record("mid_rst");
        step();
        step();
        wb_rst_n = 1'b1;
        restarted = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wb.m_cyc_o) restarted = 1;
        end
        check_eq("no_restart", restarted, 0);
        check_eq("no_restart_status", status_reg, 0);

        run_fetch(32'h600, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_dsp_equation_fetch.md
WB_DSP_EQUATION_FETCH -- requirements
Module: wb_dsp_equation_fetch

Interface
REQ-001 SHALL have port wb_clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-002 SHALL have port wb_rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port control_reg, input, 32, from the slave register block: [0] START, [1] ABORT, [2] IE; other bits ignored.
REQ-004 SHALL have port equation_address_reg, input, 32, byte address of the equation record; bits [1:0] treated as 0.
REQ-005 SHALL have port status_reg, output, 32, to the slave register block (bit map in REQ-020).
REQ-006 SHALL have Wishbone master ports m_adr_o out 32, m_dat_i in 32, m_sel_o out 4, m_we_o out 1, m_cyc_o out 1, m_stb_o out 1, m_ack_i in 1, m_err_i in 1.
REQ-007 SHALL have ports eq_op, eq_src0, eq_src1, eq_dst, output, 32 each: the fetched record words 0..3.
REQ-008 SHALL have port eq_valid, output, 1: one-cycle pulse when all four eq_* words are valid.
REQ-009 SHALL have port interrupt, output, 1: registered completion/error interrupt.

Function
REQ-010 SHALL drive m_we_o=0 and m_sel_o=4'hF at all times; all outputs SHALL be registered.
REQ-011 SHALL implement states IDLE, FETCH, GAP, DONE.
REQ-012 START SHALL be rising-edge detected on control_reg[0]; in IDLE an edge loads adr=equation_address_reg&~3, idx=0, clears done/error/timeout/aborted flags and interrupt, and enters FETCH.
REQ-013 START edges outside IDLE SHALL be ignored.
REQ-014 FETCH: m_cyc_o=m_stb_o=1; on m_ack_i, word idx is captured into its eq_* register; idx==3 -> DONE, else -> GAP with idx+1 and m_adr_o+4.
REQ-015 GAP: m_cyc_o=1, m_stb_o=0 for exactly one cycle, then FETCH; one record therefore takes at least 4 acks plus 3 gap cycles.
REQ-016 m_adr_o SHALL increment modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
REQ-017 DONE: cyc/stb=0, eq_valid=1 for one cycle, done flag set, -> IDLE.
REQ-018 m_err_i in FETCH (priority over m_ack_i the same cycle) SHALL drop cyc/stb next cycle, set error flag, leave eq_* unchanged, skip eq_valid, -> IDLE.
REQ-019 ABORT=1 in FETCH or GAP SHALL drop cyc/stb next cycle, set aborted flag, -> IDLE, no eq_valid; ABORT in IDLE has no effect; ABORT and ack in the same cycle means ABORT wins and the word is discarded.
REQ-020 status_reg: [0] busy (state!=IDLE), [1] done, [2] bus error, [3] timeout, [4] aborted, [6:5] idx, [9:8] state (IDLE=0, FETCH=1, GAP=2, DONE=3), others 0; flags sticky until next accepted START.
REQ-021 interrupt SHALL be set the cycle after done or error (or timeout) sets if IE=1, held until next accepted START; an abort SHALL NOT set it.

Reset
REQ-022 wb_rst_n low SHALL immediately force state IDLE, m_cyc_o=m_stb_o=0, m_adr_o=0, all eq_*=0, eq_valid=0, status_reg=0, interrupt=0, idx=0, START edge detector=0, mid-transaction included.
REQ-023 After release, a START bit already at 1 SHALL NOT count as an edge.

Configuration
REQ-024 With WB_DSP_FETCH_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering FETCH and count each FETCH cycle without ack/err; reaching 255 SHALL drop cyc/stb, set timeout flag (status[3]), and go IDLE.
REQ-025 Without WB_DSP_FETCH_TIMEOUT_EN, no counter SHALL exist, FETCH waits indefinitely, and status[3] SHALL read 0.

Verification
REQ-026 Record at 0x100 = {0xA1,0xB2,0xC3,0xD4}, START edge, IE=1 -> reads from 0x100,0x104,0x108,0x10C, eq_op..eq_dst = A1..D4, single eq_valid pulse, status=0x002, interrupt=1.
REQ-027 equation_address_reg=0x103 -> first m_adr_o=0x100.
REQ-028 m_err_i on the third word -> status[2]=1, eq_valid never pulses, cyc low next cycle, interrupt=1 with IE=1.
REQ-029 ABORT raised during GAP after word 1 -> status[4]=1, interrupt=0, second START refetches from word 0.
REQ-030 With macro, slave never acks -> cyc drops after 255 FETCH cycles, status[3]=1; without macro, cyc stays high past 1000 cycles.
REQ-031 wb_rst_n asserted mid-FETCH with START held high -> all outputs 0 immediately; no fetch after release until START toggles 0->1.
